// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I operand-fetch/decode stage with register scoreboard
module decode_stage #(
    parameter int NUMREGS   = 32,
    parameter int DATAWIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [31:0]          in_instr_i,
    input  logic [31:0]          in_pc_i,
    output logic                 re_a_o,
    output logic [4:0]           raddr_a_o,
    input  logic [DATAWIDTH-1:0] rdata_a_i,
    output logic                 re_b_o,
    output logic [4:0]           raddr_b_o,
    input  logic [DATAWIDTH-1:0] rdata_b_i,
    input  logic                 wb_valid_i,
    input  logic [4:0]           wb_addr_i,
    input  logic                 flush_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [31:0]          out_instr_o,
    output logic [31:0]          out_pc_o,
    output logic [DATAWIDTH-1:0] out_rs1_data_o,
    output logic [DATAWIDTH-1:0] out_rs2_data_o,
    output logic [4:0]           out_rd_o,
    output logic                 out_illegal_o
);

    generate
        if (NUMREGS != 32) begin : g_bad_numregs
            $error("decode_stage: NUMREGS must be 32");
        end
    endgenerate

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FRESH = 2'd1;
    localparam logic [1:0] HELD  = 2'd2;

    logic [1:0]           state;
    logic [31:0]          busy;
    logic [31:0]          busy_next;
    logic [31:0]          busy_eff;
    logic [31:0]          instr_q;
    logic [31:0]          pc_q;
    logic [4:0]           rd_q;
    logic                 illegal_q;
    logic                 use_rs1_q;
    logic                 use_rs2_q;
    logic                 set_busy_q;
    logic [DATAWIDTH-1:0] hold_a;
    logic [DATAWIDTH-1:0] hold_b;
    logic [DATAWIDTH-1:0] fresh_a;
    logic [DATAWIDTH-1:0] fresh_b;

    logic       uses_rs1;
    logic       uses_rs2;
    logic       writes_rd;
    logic       illegal;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       hazard;
    logic       accept;

    assign rs1 = in_instr_i[19:15];
    assign rs2 = in_instr_i[24:20];
    assign rd  = in_instr_i[11:7];

    always_comb begin
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        writes_rd = 1'b0;
        illegal   = 1'b0;
        case (in_instr_i[6:0])
            7'b0110011: begin
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
                writes_rd = 1'b1;
            end
            7'b1100011, 7'b0100011: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            7'b0010011, 7'b0000011, 7'b1100111: begin
                uses_rs1  = 1'b1;
                writes_rd = 1'b1;
            end
            7'b0110111, 7'b0010111, 7'b1101111: begin
                writes_rd = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

    // A writeback retiring this cycle already reaches the bank through its bypass.
    assign busy_eff = busy & ~(wb_valid_i ? (32'd1 << wb_addr_i) : 32'd0);

    assign hazard = (uses_rs1 & busy_eff[rs1]) |
                    (uses_rs2 & busy_eff[rs2]) |
                    (writes_rd & (rd != 5'd0) & busy_eff[rd]);

    assign in_ready_o = ~rst_i & ~flush_i & ~hazard & ((state == IDLE) | out_ready_i);
    assign accept     = in_valid_i & in_ready_o;

    assign re_a_o    = accept & uses_rs1;
    assign re_b_o    = accept & uses_rs2;
    assign raddr_a_o = re_a_o ? rs1 : 5'd0;
    assign raddr_b_o = re_b_o ? rs2 : 5'd0;

    always_comb begin
        busy_next = busy;
        if (wb_valid_i) begin
            busy_next[wb_addr_i] = 1'b0;
        end
        if (flush_i && (state != IDLE) && set_busy_q) begin
            busy_next[rd_q] = 1'b0;
        end
        if (accept && writes_rd && (rd != 5'd0)) begin
            busy_next[rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    assign fresh_a = use_rs1_q ? rdata_a_i : '0;
    assign fresh_b = use_rs2_q ? rdata_b_i : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            busy       <= '0;
            instr_q    <= '0;
            pc_q       <= '0;
            rd_q       <= '0;
            illegal_q  <= 1'b0;
            use_rs1_q  <= 1'b0;
            use_rs2_q  <= 1'b0;
            set_busy_q <= 1'b0;
            hold_a     <= '0;
            hold_b     <= '0;
        end else begin
            busy <= busy_next;
            if (flush_i) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            state <= FRESH;
                        end
                    end
                    default: begin
                        if (out_ready_i) begin
                            state <= accept ? FRESH : IDLE;
                        end else if (state == FRESH) begin
                            // Bank data is only valid for one cycle; keep it for a stalled consumer.
                            state  <= HELD;
                            hold_a <= fresh_a;
                            hold_b <= fresh_b;
                        end
                    end
                endcase
                if (accept) begin
                    instr_q    <= in_instr_i;
                    pc_q       <= in_pc_i;
                    rd_q       <= writes_rd ? rd : 5'd0;
                    illegal_q  <= illegal;
                    use_rs1_q  <= uses_rs1;
                    use_rs2_q  <= uses_rs2;
                    set_busy_q <= writes_rd && (rd != 5'd0);
                end
            end
        end
    end

    assign out_valid_o    = (state == FRESH) || (state == HELD);
    assign out_instr_o    = instr_q;
    assign out_pc_o       = pc_q;
    assign out_rd_o       = rd_q;
    assign out_illegal_o  = illegal_q;
    assign out_rs1_data_o = (state == HELD) ? hold_a : ((state == FRESH) ? fresh_a : '0);
    assign out_rs2_data_o = (state == HELD) ? hold_b : ((state == FRESH) ? fresh_b : '0);

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        re_a;
    logic [4:0]  raddr_a;
    logic [31:0] rdata_a;
    logic        re_b;
    logic [4:0]  raddr_b;
    logic [31:0] rdata_b;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_rs1;
    logic [31:0] out_rs2;
    logic [4:0]  out_rd;
    logic        out_illegal;

    always #5 clk = ~clk;

    decode_stage #(.NUMREGS(32), .DATAWIDTH(32)) dut (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_instr_i(in_instr), .in_pc_i(in_pc),
        .re_a_o(re_a), .raddr_a_o(raddr_a), .rdata_a_i(rdata_a),
        .re_b_o(re_b), .raddr_b_o(raddr_b), .rdata_b_i(rdata_b),
        .wb_valid_i(wb_valid), .wb_addr_i(wb_addr), .flush_i(flush),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_instr_o(out_instr), .out_pc_o(out_pc),
        .out_rs1_data_o(out_rs1), .out_rs2_data_o(out_rs2),
        .out_rd_o(out_rd), .out_illegal_o(out_illegal)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
        end
    endtask

    // Register bank: registered read with write-through bypass; junk when not reading.
    logic [31:0] mem [32] = '{default: 32'd0};
    int cyc = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        rdata_a <= re_a ? ((wb_valid && wb_addr == raddr_a && raddr_a != 0) ? wb_data : mem[raddr_a])
                        : (32'hDEAD0000 | 32'(cyc));
        rdata_b <= re_b ? ((wb_valid && wb_addr == raddr_b && raddr_b != 0) ? wb_data : mem[raddr_b])
                        : (32'hBEEF0000 | 32'(cyc));
        if (wb_valid && wb_addr != 0) mem[wb_addr] <= wb_data;
    end

    function automatic void classify(input logic [31:0] ins, output bit u1, output bit u2,
                                     output bit w, output bit ill);
        u1 = 0; u2 = 0; w = 0; ill = 0;
        case (ins[6:0])
            7'h33:               begin u1 = 1; u2 = 1; w = 1; end
            7'h63, 7'h23:        begin u1 = 1; u2 = 1; end
            7'h13, 7'h03, 7'h67: begin u1 = 1; w = 1; end
            7'h37, 7'h17, 7'h6F: w = 1;
            default:             ill = 1;
        endcase
    endfunction

    function automatic logic [31:0] regval(input logic [4:0] r);
        if (r == 0) return 32'd0;
        if (wb_valid && wb_addr == r) return wb_data;
        return mem[r];
    endfunction

    // Model: one output slot plus a set of registers with pending writes.
    bit          m_valid;
    logic [31:0] m_instr, m_pc, m_rs1, m_rs2, m_busy;
    logic [4:0]  m_rd;
    bit          m_ill, m_set;

    initial begin
        bit u1, u2, w, ill, haz, exp_ready, acc;
        logic [4:0]  s1, s2, d;
        logic [31:0] beff;
        m_valid = 0;
        m_busy  = 0;
        forever begin
            @(negedge clk);
            classify(in_instr, u1, u2, w, ill);
            s1 = in_instr[19:15];
            s2 = in_instr[24:20];
            d  = in_instr[11:7];
            beff = m_busy;
            if (wb_valid && wb_addr != 0) beff[wb_addr] = 1'b0;
            haz = (u1 && beff[s1]) || (u2 && beff[s2]) || (w && d != 0 && beff[d]);
            exp_ready = !rst && !flush && !haz && (!m_valid || out_ready);
            acc = in_valid && exp_ready;
            chk("m_in_ready", in_ready, exp_ready);
            chk("m_re_a", re_a, acc && u1);
            chk("m_raddr_a", raddr_a, (acc && u1) ? s1 : 5'd0);
            chk("m_re_b", re_b, acc && u2);
            chk("m_raddr_b", raddr_b, (acc && u2) ? s2 : 5'd0);
            chk("m_out_valid", out_valid, m_valid);
            chk("m_busy", dut.busy, m_busy);
            if (m_valid) begin
                chk("m_out_instr", out_instr, m_instr);
                chk("m_out_pc", out_pc, m_pc);
                chk("m_out_rs1", out_rs1, m_rs1);
                chk("m_out_rs2", out_rs2, m_rs2);
                chk("m_out_rd", out_rd, m_rd);
                chk("m_out_illegal", out_illegal, m_ill);
            end
            if (rst) begin
                m_valid = 0;
                m_busy  = 0;
            end else begin
                if (flush) begin
                    if (m_valid && m_set) beff[m_rd] = 1'b0;
                    m_valid = 0;
                end else if (acc) begin
                    m_valid = 1;
                    m_instr = in_instr;
                    m_pc    = in_pc;
                    m_rs1   = u1 ? regval(s1) : 32'd0;
                    m_rs2   = u2 ? regval(s2) : 32'd0;
                    m_rd    = w ? d : 5'd0;
                    m_ill   = ill;
                    m_set   = w && d != 0;
                    if (m_set) beff[d] = 1'b1;
                end else if (out_ready) begin
                    m_valid = 0;
                end
                m_busy = beff;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1; in_valid = 1; in_instr = 32'h00700293; in_pc = 32'h100;
        wb_valid = 0; wb_addr = 0; wb_data = 0; flush = 0; out_ready = 1;
        step();
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_instr", out_instr, 0);
        step();

        // ADDI x5,x0,7
        rst = 0;
        #1;
        chk("addi_ready", in_ready, 1);
        chk("addi_re_a", re_a, 1);
        chk("addi_raddr_a", raddr_a, 0);
        chk("addi_re_b", re_b, 0);
        step();
        in_instr = 32'h00528333; in_pc = 32'h104;   // ADD x6,x5,x5
        #1;
        chk("addi_out_valid", out_valid, 1);
        chk("addi_out_rd", out_rd, 5);
        chk("addi_out_rs1", out_rs1, 0);
        chk("addi_busy5", dut.busy[5], 1);
        chk("add_raw_stall", in_ready, 0);
        step();
        #1;
        chk("add_raw_stall2", in_ready, 0);
        wb_valid = 1; wb_addr = 5; wb_data = 32'h12345678;
        #1;
        chk("add_wb_ready", in_ready, 1);
        step();
        wb_valid = 0; in_valid = 0;
        #1;
        chk("add_rs1_bypass", out_rs1, 32'h12345678);
        chk("add_rs2_bypass", out_rs2, 32'h12345678);
        chk("add_out_rd", out_rd, 6);
        step();
        wb_valid = 1; wb_addr = 6; wb_data = 32'hA5A5A5A5;
        step();
        wb_valid = 0;

        // ADD x11,x6,x6 with execute stalled
        out_ready = 0; in_valid = 1; in_instr = 32'h006305B3; in_pc = 32'h200;
        step();
        in_instr = 32'h00300493;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("hold_valid", out_valid, 1);
            chk("hold_rs1", out_rs1, 32'hA5A5A5A5);
            chk("hold_rs2", out_rs2, 32'hA5A5A5A5);
            chk("hold_in_ready", in_ready, 0);
            step();
        end
        out_ready = 1; in_valid = 0;
        step();
        wb_valid = 1; wb_addr = 11; wb_data = 32'h0B0B0B0B;
        step();
        wb_valid = 0;

        // 8 independent OP-IMM to x1..x8
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1;
            in_instr = 32'((i << 20) | (i << 7) | 32'h13);
            in_pc = 32'(32'h300 + 4 * i);
            #1;
            chk("stream_ready", in_ready, 1);
            if (i > 1) begin
                chk("stream_valid", out_valid, 1);
                chk("stream_rd", out_rd, 32'(i - 1));
            end
            step();
        end
        in_valid = 0;
        #1;
        chk("stream_last_valid", out_valid, 1);
        chk("stream_last_rd", out_rd, 8);
        chk("stream_busy", dut.busy[8:1], 8'hFF);
        step();
        for (int i = 1; i <= 8; i++) begin
            wb_valid = 1; wb_addr = 5'(i); wb_data = 32'(32'h1000 + i);
            step();
        end
        wb_valid = 0;

        // SW x2,0(x3) then illegal opcode 0x7F (rd field 9)
        in_valid = 1; in_instr = 32'h0021A023; in_pc = 32'h400;
        #1;
        chk("sw_re_a", re_a, 1);
        chk("sw_raddr_a", raddr_a, 3);
        chk("sw_re_b", re_b, 1);
        chk("sw_raddr_b", raddr_b, 2);
        step();
        in_instr = 32'h000004FF; in_pc = 32'h404;
        #1;
        chk("sw_out_rd", out_rd, 0);
        chk("sw_out_rs1", out_rs1, 32'h1003);
        chk("sw_out_rs2", out_rs2, 32'h1002);
        chk("ill_re_a", re_a, 0);
        chk("ill_re_b", re_b, 0);
        chk("sw_busy", dut.busy, 0);
        step();
        in_valid = 0;
        #1;
        chk("ill_flag", out_illegal, 1);
        chk("ill_rd", out_rd, 0);
        step();

        // Flush while HELD, ADDI x9,x0,3
        out_ready = 0; in_valid = 1; in_instr = 32'h00300493; in_pc = 32'h500;
        step();
        in_valid = 0;
        step();
        flush = 1; in_valid = 1;
        #1;
        chk("flush_in_ready", in_ready, 0);
        chk("flush_busy9_before", dut.busy[9], 1);
        step();
        flush = 0; in_valid = 0;
        #1;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_busy9", dut.busy[9], 0);

        // Reset while HELD
        in_valid = 1;
        step();
        in_valid = 0;
        step();
        #1;
        chk("pre_rst_valid", out_valid, 1);
        rst = 1;
        step();
        rst = 0;
        #1;
        chk("rst2_out_valid", out_valid, 0);
        chk("rst2_out_instr", out_instr, 0);
        chk("rst2_out_rs1", out_rs1, 0);
        chk("rst2_out_rd", out_rd, 0);
        chk("rst2_busy", dut.busy, 0);
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
